// File: rtl/uart_inst_parser.sv
// ASCII hex instruction line parser with instruction FIFO and paced issue.
// Lines of two hex digits plus CR/LF become single-cycle instruction strobes.
module uart_inst_parser #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INST_GAP   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_valid,
  output logic [7:0]                  o_inst,
  output logic                        o_inst_valid,
  output logic                        o_err,
  output logic                        o_ovf,
  output logic [7:0]                  o_err_cnt,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = $clog2(INST_GAP + 1);
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GapReload = GW'(INST_GAP - 1);

  typedef enum logic [1:0] {StIdle, StHi, StLo, StDiscard} state_e;

  state_e state_q, state_d;

  logic       rx_hex, rx_eol;
  logic [3:0] rx_nib;
  logic       err_set, commit, hi_load, lo_load;
  logic       full, empty, push, pop, ovf_set;

  logic [3:0]    hi_q, lo_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    inst_q;
  logic          inst_valid_q, err_q, ovf_q;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [8:0]    err_sum;

  // Character classification of the incoming byte.
  always_comb begin
    rx_eol = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    rx_hex = 1'b0;
    rx_nib = 4'h0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      rx_hex = 1'b1;
      rx_nib = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
      rx_hex = 1'b1;
      rx_nib = i_rx_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_hex) begin
            state_d = StHi;
          end else if (!rx_eol) begin
            state_d = StDiscard;
          end
        end
        StHi: begin
          if (rx_hex) begin
            state_d = StLo;
          end else if (rx_eol) begin
            state_d = StIdle;
          end else begin
            state_d = StDiscard;
          end
        end
        StLo:      state_d = rx_eol ? StIdle : StDiscard;
        StDiscard: state_d = rx_eol ? StIdle : StDiscard;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    err_set = 1'b0;
    commit  = 1'b0;
    hi_load = 1'b0;
    lo_load = 1'b0;
    if (i_rx_valid) begin
      unique case (state_q)
        StIdle: begin
          hi_load = rx_hex;
          err_set = !rx_hex && !rx_eol;
        end
        StHi: begin
          lo_load = rx_hex;
          err_set = !rx_hex;
        end
        StLo: begin
          commit  = rx_eol;
          err_set = !rx_eol;
        end
        default: ;
      endcase
    end
  end

  // Full is judged on start-of-cycle occupancy, so a same-cycle pop cannot save a commit.
  always_comb begin
    full    = (cnt_q == FullCnt);
    empty   = (cnt_q == '0);
    push    = commit && !full;
    ovf_set = commit && full;
    pop     = !empty && (gap_q == '0);

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (pop) begin
      gap_d = GapReload;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end else begin
      gap_d = gap_q;
    end

    err_sum   = {1'b0, err_cnt_q} + {8'h00, err_set} + {8'h00, ovf_set};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {hi_q, lo_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q         <= '0;
      lo_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (hi_load) begin
        hi_q <= rx_nib;
      end
      if (lo_load) begin
        lo_q <= rx_nib;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        inst_q   <= mem_q[rd_ptr_q];
      end
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      inst_valid_q <= pop;
      err_q        <= err_set;
      ovf_q        <= ovf_set;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_err        = err_q;
  assign o_ovf        = ovf_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_inst_parser.sv
// Bench for uart_inst_parser: line-level reference model checked every cycle,
// plus table-driven line vectors and hand-written overflow/reset/saturation runs.
module tb_uart_inst_parser;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] o_inst;
  logic       o_inst_valid, o_err, o_ovf;
  logic [7:0] o_err_cnt;
  logic [2:0] o_fifo_cnt;

  uart_inst_parser #(.FIFO_DEPTH(DEPTH), .INST_GAP(GAP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_inst      (o_inst),
    .o_inst_valid(o_inst_valid),
    .o_err       (o_err),
    .o_ovf       (o_ovf),
    .o_err_cnt   (o_err_cnt),
    .o_fifo_cnt  (o_fifo_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: line text buffer, instruction queue, next legal issue cycle.
  logic [7:0] line_buf[$];
  logic [7:0] q[$];
  bit         bad;
  longint     cyc, next_pop;
  logic [7:0] m_inst;
  bit         m_valid, m_err, m_ovf;
  int         m_err_cnt;

  // Observations of DUT outputs.
  int         n_strobe, n_err, n_ovf, peak;
  logic [7:0] last_inst;
  longint     strobe_cyc[$];
  logic [7:0] strobe_val[$];

  function automatic bit is_hex(logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hexval(logic [7:0] c);
    logic [7:0] v;
    if (c <= 8'h39) v = c - 8'h30;
    else            v = (c & 8'h0F) + 8'd9;
    return v[3:0];
  endfunction

  task automatic model_reset();
    line_buf.delete();
    q.delete();
    bad = 0;
    cyc = 0;
    next_pop = 0;
    m_inst = 8'h00;
    m_valid = 0;
    m_err = 0;
    m_ovf = 0;
    m_err_cnt = 0;
  endtask

  task automatic model_edge(bit v, logic [7:0] d);
    bit         err, commit, ovf, was_full;
    logic [7:0] word;
    err = 0; commit = 0; ovf = 0; word = 8'h00;
    was_full = (q.size() == DEPTH);
    if (v) begin
      if (d == 8'h0D || d == 8'h0A) begin
        if (!bad && line_buf.size() == 2) begin
          commit = 1;
          word = {hexval(line_buf[0]), hexval(line_buf[1])};
        end else if (!bad && line_buf.size() == 1) begin
          err = 1;
        end
        line_buf.delete();
        bad = 0;
      end else if (!bad) begin
        if (!is_hex(d) || line_buf.size() == 2) begin
          err = 1;
          bad = 1;
        end else begin
          line_buf.push_back(d);
        end
      end
    end
    m_valid = 0;
    if (q.size() > 0 && cyc >= next_pop) begin
      m_inst = q.pop_front();
      m_valid = 1;
      next_pop = cyc + GAP;
    end
    if (commit) begin
      if (was_full) ovf = 1;
      else q.push_back(word);
    end
    m_err = err;
    m_ovf = ovf;
    m_err_cnt = m_err_cnt + int'(err) + int'(ovf);
    if (m_err_cnt > 255) m_err_cnt = 255;
    cyc++;
  endtask

  task automatic check_model();
    tests++;
    if (o_inst !== m_inst || o_inst_valid !== m_valid || o_err !== m_err ||
        o_ovf !== m_ovf || int'(o_err_cnt) != m_err_cnt || int'(o_fifo_cnt) != q.size()) begin
      fails++;
      $display("FAIL model cyc=%0d got inst=%h v=%b err=%b ovf=%b ecnt=%0d fcnt=%0d want inst=%h v=%b err=%b ovf=%b ecnt=%0d fcnt=%0d",
               cyc, o_inst, o_inst_valid, o_err, o_ovf, o_err_cnt, o_fifo_cnt,
               m_inst, m_valid, m_err, m_ovf, m_err_cnt, q.size());
    end
  endtask

  task automatic check_int(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_obs();
    n_strobe = 0; n_err = 0; n_ovf = 0; peak = 0; last_inst = 8'h00;
    strobe_cyc.delete();
    strobe_val.delete();
  endtask

  task automatic step(bit v, logic [7:0] d);
    rx_valid = v;
    rx_data = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_model();
    if (o_inst_valid) begin
      n_strobe++;
      last_inst = o_inst;
      strobe_cyc.push_back(cyc);
      strobe_val.push_back(o_inst);
    end
    if (o_err) n_err++;
    if (o_ovf) n_ovf++;
    if (int'(o_fifo_cnt) > peak) peak = int'(o_fifo_cnt);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 8'h00);
  endtask

  task automatic send_line(string s, logic [7:0] eol);
    for (int i = 0; i < s.len(); i++) step(1, s[i]);
    step(1, eol);
  endtask

  // Async reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rx_valid = 0;
    rst_n = 0;
    #2;
    tests++;
    if (o_inst !== 8'h00 || o_inst_valid !== 1'b0 || o_err !== 1'b0 || o_ovf !== 1'b0 ||
        o_err_cnt !== 8'h00 || o_fifo_cnt !== 3'd0) begin
      fails++;
      $display("FAIL reset_outputs got inst=%h v=%b err=%b ovf=%b ecnt=%0d fcnt=%0d want all 0",
               o_inst, o_inst_valid, o_err, o_ovf, o_err_cnt, o_fifo_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    string      text;
    logic [7:0] eol;
    int         strobes;
    logic [7:0] inst;
    int         err_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    longint cr_cyc;
    vecs[0] = '{"3A",  8'h0D, 1, 8'h3A, 0};
    vecs[1] = '{"a5",  8'h0A, 1, 8'hA5, 0};
    vecs[2] = '{"",    8'h0D, 0, 8'h00, 0};
    vecs[3] = '{"",    8'h0D, 0, 8'h00, 0};
    vecs[4] = '{"3G",  8'h0D, 0, 8'h00, 1};
    vecs[5] = '{"3",   8'h0D, 0, 8'h00, 2};
    vecs[6] = '{"3A7", 8'h0D, 0, 8'h00, 3};
    vecs[7] = '{"12",  8'h0D, 1, 8'h12, 3};
    vecs[8] = '{"Ff",  8'h0A, 1, 8'hFF, 3};
    vecs[9] = '{"x1",  8'h0D, 0, 8'h00, 4};

    model_reset();
    do_reset();

    // Table-driven line vectors.
    for (int i = 0; i < 10; i++) begin
      clear_obs();
      send_line(vecs[i].text, vecs[i].eol);
      cr_cyc = cyc;
      idle(20);
      check_int($sformatf("vec%0d_strobes", i), n_strobe, vecs[i].strobes);
      if (vecs[i].strobes > 0 && strobe_cyc.size() > 0) begin
        check_int($sformatf("vec%0d_inst", i), int'(last_inst), int'(vecs[i].inst));
        check_int($sformatf("vec%0d_latency", i), int'(strobe_cyc[0] - cr_cyc), 1);
      end
      check_int($sformatf("vec%0d_err_cnt", i), int'(o_err_cnt), vecs[i].err_cnt);
    end

    // Overflow and pacing: six commands back to back.
    do_reset();
    clear_obs();
    for (int i = 1; i <= 6; i++) send_line($sformatf("%02x", i), 8'h0D);
    idle(100);
    check_int("ovf_strobes", n_strobe, 5);
    for (int i = 0; i < strobe_val.size(); i++)
      check_int($sformatf("ovf_val%0d", i), int'(strobe_val[i]), i + 1);
    for (int i = 1; i < strobe_cyc.size(); i++)
      check_int($sformatf("ovf_gap%0d", i), int'(strobe_cyc[i] - strobe_cyc[i-1]), GAP);
    check_int("ovf_pulses", n_ovf, 1);
    check_int("ovf_peak", peak, 4);
    check_int("ovf_err_cnt", int'(o_err_cnt), 1);

    // Reset mid-line: partial line lost, next "4\r" is a short line.
    step(1, "3");
    do_reset();
    clear_obs();
    send_line("4", 8'h0D);
    idle(20);
    check_int("rst_err", n_err, 1);
    check_int("rst_strobes", n_strobe, 0);

    // Error counter saturation.
    do_reset();
    clear_obs();
    for (int i = 0; i < 260; i++) send_line("Z", 8'h0D);
    check_int("sat_err_cnt", int'(o_err_cnt), 255);
    send_line("FF", 8'h0D);
    idle(20);
    check_int("sat_strobes", n_strobe, 1);
    check_int("sat_inst", int'(last_inst), 255);
    check_int("sat_hold", int'(o_err_cnt), 255);

    // Randomized byte stream against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int         r;
      logic [7:0] b;
      logic [7:0] hexset [16];
      hexset = '{8'h30, 8'h31, 8'h35, 8'h39, 8'h41, 8'h43, 8'h46, 8'h61,
                 8'h62, 8'h66, 8'h37, 8'h32, 8'h44, 8'h65, 8'h34, 8'h38};
      r = int'($urandom_range(0, 99));
      if (r < 55)      b = hexset[$urandom_range(0, 15)];
      else if (r < 80) b = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      else             b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, b);
    end
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
